// File: rtl/line_burst_adapter.sv
// Memory-side responder for the cache line interface: turns one whole-line read or
// write into a fixed-length burst of BEATS beats on the physical-memory port.
module line_burst_adapter #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  localparam int BEATS      = LINE_WIDTH / BURST_WIDTH,
  localparam int CNT_W      = $clog2(BEATS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  input  logic [31:0]            address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_o,
  input  logic                   pmem_resp,
  output logic [BURST_WIDTH-1:0] burst_i,
  output logic [31:0]            pmem_address,
  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic [1:0]             o_dbg_state
);

  // Handshake: a beat moves on every cycle where pmem_read or pmem_write is high
  // together with pmem_resp; with pmem_resp low the request, beat and counter hold.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [31:0] LINE_MASK = ~(32'(LINE_WIDTH / 8) - 32'd1);

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [LINE_WIDTH-1:0] r_wline;
  logic [LINE_WIDTH-1:0] r_line_o;
  logic [31:0]           r_addr;
  logic                  w_last;

  assign w_last = (r_cnt == CNT_W'(BEATS - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (write_i)     w_next = S_WR;
        else if (read_i) w_next = S_RD;
      end
      S_RD:    if (pmem_resp && w_last) w_next = S_DONE;
      S_WR:    if (pmem_resp && w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The counter wraps to zero on the last beat, so DONE always starts with cnt=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_wline  <= '0;
      r_line_o <= '0;
      r_addr   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (write_i) begin
            r_addr  <= address_i & LINE_MASK;
            r_wline <= line_i;
          end else if (read_i) begin
            r_addr  <= address_i & LINE_MASK;
          end
        end
        S_RD: begin
          if (pmem_resp) begin
            r_line_o[BURST_WIDTH*r_cnt +: BURST_WIDTH] <= burst_o;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WR: begin
          if (pmem_resp) r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign pmem_read    = (r_state == S_RD);
  assign pmem_write   = (r_state == S_WR);
  assign resp_o       = (r_state == S_DONE);
  assign burst_i      = pmem_write ? r_wline[BURST_WIDTH*r_cnt +: BURST_WIDTH] : '0;
  assign line_o       = r_line_o;
  assign pmem_address = r_addr;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed bench for line_burst_adapter: read/write bursts, stalls, mid-burst reset,
// write priority, back-to-back request and ignored mid-burst input changes.
module tb_line_burst_adapter;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [63:0]  burst_o;
  logic         pmem_resp;
  logic [63:0]  burst_i;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [1:0]   o_dbg_state;

  int n_cmp;
  int n_err;
  logic [63:0] exp_q[$];

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [255:0] W_LINE = {64'h0123456789ABCDEF, 64'hDEADBEEFCAFEF00D,
                                     64'h5555AAAA3333CCCC, 64'h0F0F0F0F89ABCDEF};
  localparam logic [255:0] RD_LINE1 = {64'h4444444444444444, 64'h3333333333333333,
                                       64'h2222222222222222, 64'h1111111111111111};
  localparam logic [255:0] RD_LINE2 = {64'h0000000000000004, 64'h0000000000000003,
                                       64'h0000000000000002, 64'h0000000000000001};

  line_burst_adapter dut (
    .clk          (clk),
    .rst          (rst),
    .line_i       (line_i),
    .address_i    (address_i),
    .read_i       (read_i),
    .write_i      (write_i),
    .line_o       (line_o),
    .resp_o       (resp_o),
    .burst_o      (burst_o),
    .pmem_resp    (pmem_resp),
    .burst_i      (burst_i),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .o_dbg_state  (o_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [63:0] rd_beats [4];
    logic        stall_pat [6];
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_o = '0; pmem_resp = 1'b0;

    tick(); tick();
    check("rst_state", 256'(o_dbg_state), 256'(ST_IDLE));
    check("rst_resp", 256'(resp_o), 256'd0);
    check("rst_rd_wr", 256'({pmem_read, pmem_write}), 256'd0);
    check("rst_line_o", line_o, 256'd0);
    check("rst_burst_i", 256'(burst_i), 256'd0);
    check("rst_addr", 256'(pmem_address), 256'd0);
    rst = 1'b1;
    tick();

    // Read, no stall
    rd_beats = '{64'h1111111111111111, 64'h2222222222222222,
                 64'h3333333333333333, 64'h4444444444444444};
    read_i = 1'b1; address_i = 32'h0000_1234;
    tick();
    read_i = 1'b0; address_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      check("rd_pmem_read", 256'(pmem_read), 256'd1);
      check("rd_addr", 256'(pmem_address), 256'h0000_1220);
      check("rd_no_resp", 256'(resp_o), 256'd0);
      burst_o = rd_beats[i]; pmem_resp = 1'b1;
      tick();
    end
    pmem_resp = 1'b0;
    check("rd_resp", 256'(resp_o), 256'd1);
    check("rd_done_no_req", 256'({pmem_read, pmem_write}), 256'd0);
    check("rd_line", line_o, RD_LINE1);
    tick();
    check("rd_resp_one_cycle", 256'(resp_o), 256'd0);
    check("rd_line_hold", line_o, RD_LINE1);

    // Write, no stall; inputs changed mid-burst must be ignored
    exp_q.push_back(64'h0F0F0F0F89ABCDEF);
    exp_q.push_back(64'h5555AAAA3333CCCC);
    exp_q.push_back(64'hDEADBEEFCAFEF00D);
    exp_q.push_back(64'h0123456789ABCDEF);
    write_i = 1'b1; line_i = W_LINE; address_i = 32'h8000_0040;
    tick();
    write_i = 1'b0; line_i = '0; address_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      check("wr_pmem_write", 256'({pmem_read, pmem_write}), 256'b01);
      check("wr_addr", 256'(pmem_address), 256'h8000_0040);
      check("wr_beat", 256'(burst_i), 256'(exp_q.pop_front()));
      pmem_resp = 1'b1;
      tick();
    end
    pmem_resp = 1'b0;
    check("wr_resp", 256'(resp_o), 256'd1);
    check("wr_line_o_kept", line_o, RD_LINE1);
    tick();

    // Write with two stall cycles between beats 1 and 2
    exp_q.push_back(64'h0F0F0F0F89ABCDEF);
    exp_q.push_back(64'h5555AAAA3333CCCC);
    exp_q.push_back(64'hDEADBEEFCAFEF00D);
    exp_q.push_back(64'h0123456789ABCDEF);
    stall_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    write_i = 1'b1; line_i = W_LINE; address_i = 32'h0000_0100;
    tick();
    write_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("st_pmem_write", 256'(pmem_write), 256'd1);
      check("st_no_resp", 256'(resp_o), 256'd0);
      pmem_resp = stall_pat[i];
      if (stall_pat[i]) check("st_beat", 256'(burst_i), 256'(exp_q.pop_front()));
      else              check("st_beat_hold", 256'(burst_i), 256'(exp_q[0]));
      tick();
    end
    pmem_resp = 1'b0;
    check("st_resp_cycle7", 256'(resp_o), 256'd1);
    tick();

    // Reset in the middle of a read, after beat 2
    read_i = 1'b1; address_i = 32'h0000_2000;
    tick();
    read_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      burst_o = {8{8'hA0 + 8'(i)}}; pmem_resp = 1'b1;
      tick();
    end
    pmem_resp = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_state", 256'(o_dbg_state), 256'(ST_IDLE));
    check("mid_rst_outs", 256'({resp_o, pmem_read, pmem_write}), 256'd0);
    check("mid_rst_line_o", line_o, 256'd0);
    check("mid_rst_addr", 256'(pmem_address), 256'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_resp", 256'(resp_o), 256'd0);
    end

    // Following read completes normally
    rd_beats = '{64'd1, 64'd2, 64'd3, 64'd4};
    read_i = 1'b1; address_i = 32'h0000_3FFF;
    tick();
    read_i = 1'b0;
    check("rd2_addr", 256'(pmem_address), 256'h0000_3FE0);
    check("rd2_state", 256'(o_dbg_state), 256'(ST_RD));
    for (int i = 0; i < 4; i++) begin
      burst_o = rd_beats[i]; pmem_resp = 1'b1;
      tick();
    end
    pmem_resp = 1'b0;
    check("rd2_resp", 256'(resp_o), 256'd1);
    check("rd2_line", line_o, RD_LINE2);
    tick();

    // Both requests high: write wins; request held past resp_o starts another
    exp_q.push_back(64'h0F0F0F0F89ABCDEF);
    exp_q.push_back(64'h5555AAAA3333CCCC);
    exp_q.push_back(64'hDEADBEEFCAFEF00D);
    exp_q.push_back(64'h0123456789ABCDEF);
    read_i = 1'b1; write_i = 1'b1; line_i = W_LINE; address_i = 32'h0000_0040;
    tick();
    check("prio_write", 256'({pmem_read, pmem_write}), 256'b01);
    for (int i = 0; i < 4; i++) begin
      check("prio_beat", 256'(burst_i), 256'(exp_q.pop_front()));
      pmem_resp = 1'b1;
      tick();
    end
    pmem_resp = 1'b0;
    check("prio_resp", 256'(resp_o), 256'd1);
    line_i = ~W_LINE;
    tick();
    check("held_idle", 256'(o_dbg_state), 256'(ST_IDLE));
    check("held_no_resp", 256'(resp_o), 256'd0);
    tick();
    read_i = 1'b0; write_i = 1'b0;
    exp_q.push_back(64'hF0F0F0F076543210);
    exp_q.push_back(64'hAAAA5555CCCC3333);
    exp_q.push_back(64'h2152411035010FF2);
    exp_q.push_back(64'hFEDCBA9876543210);
    check("held_second_write", 256'({pmem_read, pmem_write}), 256'b01);
    for (int i = 0; i < 4; i++) begin
      check("held_beat", 256'(burst_i), 256'(exp_q.pop_front()));
      pmem_resp = 1'b1;
      tick();
    end
    pmem_resp = 1'b0;
    check("held_resp", 256'(o_dbg_state), 256'(ST_DONE));
    check("held_line_o_kept", line_o, RD_LINE2);
    tick();
    check("final_idle", 256'(o_dbg_state), 256'(ST_IDLE));

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
